// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP MAC pipeline and its upstream sequencer.
// Holds the fp32 width, the +0.0 encoding, and the sequencer state enum.
package fp_mac_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/fp_dot_seq_if.sv
// Operand-pair stream and result stream of the dot-product sequencer.
// Both streams use valid/ready: a beat transfers on a rising clk edge where valid and
// ready are both 1; the source holds valid and its payload stable until that edge.
interface fp_dot_seq_if
    import fp_mac_pkg::*;
#(
    parameter int LEN_W = 16
);

    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] in_a;
    logic [FP_W-1:0] in_b;
    logic            in_last;

    logic             res_valid;
    logic             res_ready;
    logic [FP_W-1:0]  res_data;
    logic [LEN_W-1:0] res_count;

    modport master (
        output in_valid, in_a, in_b, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, res_ready,
        output in_ready, res_valid, res_data, res_count
    );

endinterface

// File: rtl/fp_dot_seq.sv
// Sequencer in front of the FP MAC: clears the accumulator per vector, feeds pairs or
// +0.0 bubbles, waits MAC_LAT edges after the last pair, then presents the dot product.
module fp_dot_seq
    import fp_mac_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 3
) (
    input  logic            clk,
    input  logic            reset,
    fp_dot_seq_if.slave     bus,
    output logic            mac_clr,
    output logic [FP_W-1:0] mac_a,
    output logic [FP_W-1:0] mac_b,
    input  logic [FP_W-1:0] mac_out,
    output seq_state_t      state
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    seq_state_t       state_next;
    logic [LEN_W-1:0] pair_cnt;
    logic [DW-1:0]    drain_cnt;
    logic             take;
    logic             drain_end;

    assign bus.in_ready = (state == FEED);
    assign take         = (state == FEED) && bus.in_valid;
    assign drain_end    = (state == DRAIN) && (drain_cnt == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = CLEAR;
            CLEAR:   state_next = FEED;
            FEED:    if (take && bus.in_last) state_next = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_next = DONE;
            DONE:    if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State plus every registered output; mac_clr is registered from the next state so
    // it is high exactly while the FSM sits in CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mac_clr       <= 1'b1;
            mac_a         <= FP_ZERO;
            mac_b         <= FP_ZERO;
            bus.res_valid <= 1'b0;
            bus.res_data  <= FP_ZERO;
            bus.res_count <= '0;
        end else begin
            state   <= state_next;
            mac_clr <= (state_next == CLEAR);
            mac_a   <= take ? bus.in_a : FP_ZERO;
            mac_b   <= take ? bus.in_b : FP_ZERO;
            if (drain_end) begin
                bus.res_valid <= 1'b1;
                bus.res_data  <= mac_out;
                bus.res_count <= pair_cnt;
            end else if ((state == DONE) && bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (state == CLEAR)) begin
            pair_cnt <= '0;
        end else if (take && (pair_cnt != {LEN_W{1'b1}})) begin
            pair_cnt <= pair_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (take && bus.in_last) begin
            drain_cnt <= DW'(MAC_LAT - 1);
        end else if ((state == DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_dot_seq.sv
// Directed bench for fp_dot_seq with a behavioural two-stage MAC beside it and a
// result scoreboard fed by the stimulus process and drained by a monitor.
module tb_fp_dot_seq;
    import fp_mac_pkg::*;

    localparam int LEN_W   = 16;
    localparam int MAC_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mac_clr;
    logic [31:0] mac_a, mac_b, mac_out;
    seq_state_t  state;

    always #5 clk = ~clk;

    fp_dot_seq_if #(.LEN_W(LEN_W)) bus ();

    fp_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .mac_clr (mac_clr),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_out (mac_out),
        .state   (state)
    );

    // fp32 <-> real for normal numbers and zero, enough for the exact vectors used here
    function automatic real f2r(input logic [31:0] x);
        int          e;
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        e = int'(x[30:23]) - 127 + 1023;
        d = {x[31], e[10:0], x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        int          e;
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // MAC model: product stage then accumulate stage; final sum samplable MAC_LAT edges after load
    logic [31:0] prod, acc;
    assign mac_out = acc;
    always @(posedge clk) begin
        if (mac_clr) begin
            prod <= 32'h0;
            acc  <= 32'h0;
        end else begin
            prod <= r2f(f2r(mac_a) * f2r(mac_b));
            acc  <= r2f(f2r(acc) + f2r(prod));
        end
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          clr_cycles = 0;
    logic [47:0] exp_q[$];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a result beat is compared on the negedge before the edge that transfers it
    always @(negedge clk) begin
        logic [47:0] e;
        if (mac_clr) clr_cycles++;
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL result_unexpected: got %h expected none", {bus.res_count, bus.res_data});
            end else begin
                e = exp_q.pop_front();
                check("result", {bus.res_count, bus.res_data}, e);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last, input int gap);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (gap > 0) begin
            check("mac_load", {16'h0, mac_a}, {16'h0, a});
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                check("bubble", {mac_a, 16'h0}, 48'h0);
                check("bubble_b", {16'h0, mac_b}, 48'h0);
            end
        end
    endtask

    task automatic wait_results();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL result_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 48'(state), 48'(IDLE));
        check({tag, "_in_ready"}, 48'(bus.in_ready), 48'h0);
        check({tag, "_mac_clr"}, 48'(mac_clr), 48'h1);
        check({tag, "_mac_ab"}, {mac_a, mac_b[15:0]}, 48'h0);
        check({tag, "_res_valid"}, 48'(bus.res_valid), 48'h0);
        check({tag, "_res"}, {bus.res_count, bus.res_data}, 48'h0);
    endtask

    initial begin
        int clr_before;
        bit seen;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'h0;
        bus.in_b      = 32'h0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // 1*2 + 3*4 + 0.5*8 = 18.0
        exp_q.push_back({16'd3, 32'h4190_0000});
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 0);
        send(32'h4040_0000, 32'h4080_0000, 1'b0, 0);
        send(32'h3F00_0000, 32'h4100_0000, 1'b1, 0);
        wait_results();
        check("post_hs_res_valid", 48'(bus.res_valid), 48'h0);
        check("post_hs_in_ready", 48'(bus.in_ready), 48'h0);

        // back-to-back single-pair vector: 2*2 = 4.0, one clear pulse in between
        clr_before = clr_cycles;
        exp_q.push_back({16'd1, 32'h4080_0000});
        send(32'h4000_0000, 32'h4000_0000, 1'b1, 0);
        check("clr_pulses", 48'(clr_cycles - clr_before), 48'h1);
        wait_results();

        // same 18.0 vector with two idle cycles between beats
        exp_q.push_back({16'd3, 32'h4190_0000});
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 2);
        send(32'h4040_0000, 32'h4080_0000, 1'b0, 2);
        send(32'h3F00_0000, 32'h4100_0000, 1'b1, 0);
        wait_results();

        // hold the result with res_ready low while the source keeps offering a pair
        bus.res_ready = 1'b0;
        exp_q.push_back({16'd1, 32'h4080_0000});
        send(32'h4000_0000, 32'h4000_0000, 1'b1, 0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                seen = 1;
                break;
            end
        end
        check("done_reached", 48'(seen), 48'h1);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h4040_0000;
        bus.in_b     = 32'h4040_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 48'(bus.res_valid), 48'h1);
            check("hold_data", {bus.res_count, bus.res_data}, {16'd1, 32'h4080_0000});
            check("hold_in_ready", 48'(bus.in_ready), 48'h0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_res_valid", 48'(bus.res_valid), 48'h0);
        check("release_queue", 48'(exp_q.size()), 48'h0);

        // reset in the middle of a vector, then a fresh 1*1 vector
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 0);
        send(32'h4040_0000, 32'h4080_0000, 1'b0, 0);
        check("mid_state_feed", 48'(state), 48'(FEED));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back({16'd1, 32'h3F80_0000});
        send(32'h3F80_0000, 32'h3F80_0000, 1'b1, 0);
        wait_results();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
